// File: rtl/regfile_pkg.sv
// Shared constants, dump FSM states and the read-mux select
// rule used by the register file read ports and dump beat load.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } dump_st_e;

  typedef enum logic [1:0] {
    SEL_RF   = 2'd0,
    SEL_ZERO = 2'd1,
    SEL_BYP  = 2'd2
  } rd_sel_e;

  // r0 wins over bypass so a write to r0 never leaks through
  function automatic rd_sel_e rd_sel(
    input bit   zero_reg,
    input bit   bypass,
    input logic is_zero,
    input logic wr_hit
  );
    if (zero_reg && is_zero)
      return SEL_ZERO;
    if (bypass && wr_hit)
      return SEL_BYP;
    return SEL_RF;
  endfunction

endpackage

// File: rtl/regfile_dump_if.sv
// Back-pressured dump stream: the register file is the master,
// the capture side is the slave.
interface regfile_dump_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              dump_busy;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;

  modport master (
    output dump_busy,
    output dump_valid,
    input  dump_ready,
    output dump_addr,
    output dump_data,
    output dump_last
  );

  modport slave (
    input  dump_busy,
    input  dump_valid,
    output dump_ready,
    input  dump_addr,
    input  dump_data,
    input  dump_last
  );

endinterface

// File: rtl/regfile_dump_ctrl.sv
// Dump FSM: walks idx 0..DEPTH-1 and holds each beat in a
// register so stalls never see later writes.
module regfile_dump_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump_start,
  output logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  regfile_dump_if.master    dump
);

  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  dump_st_e          state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] beat_data;
  logic              beat_last;
  logic              ld_en;
  logic              accept;

  assign accept = (state == ST_STREAM) && dump.dump_ready;

  always_comb begin
    ld_en   = 1'b0;
    ld_addr = idx + ADDR_W'(1);
    unique case (1'b1)
      (state == ST_IDLE): begin
        ld_en   = dump_start;
        ld_addr = '0;
      end
      (state == ST_STREAM): begin
        ld_en = accept && (idx != LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      beat_data <= '0;
      beat_last <= 1'b0;
    end else if (ld_en) begin
      state     <= ST_STREAM;
      idx       <= ld_addr;
      beat_data <= ld_data;
      beat_last <= (ld_addr == LAST);
    end else if (accept) begin
      state     <= ST_IDLE;
      beat_last <= 1'b0;
    end
  end

  assign dump.dump_busy  = (state == ST_STREAM);
  assign dump.dump_valid = (state == ST_STREAM);
  assign dump.dump_addr  = idx;
  assign dump.dump_data  = beat_data;
  assign dump.dump_last  = beat_last;

endmodule

// File: rtl/regfile_dump.sv
// 2R/1W register file with optional r0 hardwiring, write
// bypass and a full-contents dump stream.
module regfile_dump
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              dump_start,
  regfile_dump_if.master    dump
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] rf [DEPTH];
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              wr_ok;

  assign wr_ok = wr_en && !(ZERO_REG && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        rf[i] <= '0;
    end else if (wr_ok) begin
      rf[wr_addr] <= wr_data;
    end
  end

  function automatic logic [DATA_W-1:0] rd_mux(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    rd_sel_e s;
    s = rd_sel(ZERO_REG, BYPASS, a == '0, we && (wa == a));
    unique case (s)
      SEL_ZERO: return '0;
      SEL_BYP:  return wd;
      default:  return stored;
    endcase
  endfunction

  assign rd_data_a = rd_mux(rd_addr_a, rf[rd_addr_a],
                            wr_en, wr_addr, wr_data);
  assign rd_data_b = rd_mux(rd_addr_b, rf[rd_addr_b],
                            wr_en, wr_addr, wr_data);
  assign ld_data   = rd_mux(ld_addr, rf[ld_addr],
                            wr_en, wr_addr, wr_data);

  regfile_dump_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .dump_start (dump_start),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .dump       (dump)
  );

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: default 32x32 instance plus
// an 8x16 instance without a hardwired r0.
module tb_regfile_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [31:0] rd_data_a, rd_data_b, wr_data;
  logic        wr_en, dump_start;

  logic [2:0]  s_rd_addr_a, s_rd_addr_b, s_wr_addr;
  logic [15:0] s_rd_data_a, s_rd_data_b, s_wr_data;
  logic        s_wr_en, s_dump_start;

  int vecs = 0;
  int errs = 0;
  logic [31:0] mem [32];

  regfile_dump_if #(.DATA_W(32), .ADDR_W(5)) dif ();
  regfile_dump_if #(.DATA_W(16), .ADDR_W(3)) sif ();

  regfile_dump dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .dump_start (dump_start),
    .dump       (dif)
  );

  regfile_dump #(
    .DATA_W   (16),
    .ADDR_W   (3),
    .ZERO_REG (1'b0),
    .BYPASS   (1'b1)
  ) u_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr_a  (s_rd_addr_a),
    .rd_addr_b  (s_rd_addr_b),
    .rd_data_a  (s_rd_data_a),
    .rd_data_b  (s_rd_data_b),
    .wr_en      (s_wr_en),
    .wr_addr    (s_wr_addr),
    .wr_data    (s_wr_data),
    .dump_start (s_dump_start),
    .dump       (sif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    dump_start = 1'b0; dif.dump_ready = 1'b0;
    s_rd_addr_a = '0; s_rd_addr_b = '0;
    s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0;
    s_dump_start = 1'b0; sif.dump_ready = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    #3;
    vecs++;
    if ({dif.dump_busy, dif.dump_valid, dif.dump_last,
         dif.dump_addr, dif.dump_data} !== '0) begin
      errs++;
      $display("FAIL reset_dump: got busy=%b valid=%b last=%b addr=%h data=%h required all 0",
               dif.dump_busy, dif.dump_valid, dif.dump_last,
               dif.dump_addr, dif.dump_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(31 - i);
      #1;
      vecs++;
      if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
        errs++;
        $display("FAIL reset_read r%0d: got a=%h b=%h required 0",
                 i, rd_data_a, rd_data_b);
      end
    end
  endtask

  task automatic test_write_read();
    tick();
    wr_en = 1'b1; wr_addr = 5'd16; wr_data = 32'h0000_000A;
    tick();
    wr_en = 1'b0;
    mem[16] = 32'h0000_000A;
    rd_addr_a = 5'd16;
    #1;
    vecs++;
    if (rd_data_a !== 32'h0000_000A) begin
      errs++;
      $display("FAIL write_read r16: got %h required 0000000a", rd_data_a);
    end
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEAD_BEEF;
    rd_addr_a = 5'd0;
    #1;
    vecs++;
    if (rd_data_a !== 32'h0) begin
      errs++;
      $display("FAIL zero_reg_same_cycle: got %h required 0", rd_data_a);
    end
    tick();
    wr_en = 1'b0;
    rd_addr_b = 5'd0;
    #1;
    vecs++;
    if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
      errs++;
      $display("FAIL zero_reg_after: got a=%h b=%h required 0",
               rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_bypass();
    rd_addr_a = 5'd2; rd_addr_b = 5'd2;
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h45;
    #1;
    vecs++;
    if (rd_data_a !== 32'h45 || rd_data_b !== 32'h45) begin
      errs++;
      $display("FAIL bypass r2: got a=%h b=%h required 45",
               rd_data_a, rd_data_b);
    end
    tick();
    wr_en = 1'b0;
    mem[2] = 32'h45;
    #1;
    vecs++;
    if (rd_data_a !== 32'h45) begin
      errs++;
      $display("FAIL bypass_stored r2: got %h required 45", rd_data_a);
    end
  endtask

  task automatic test_dump_full();
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'd20;
    tick();
    wr_addr = 5'd17; wr_data = 32'd6;
    tick();
    wr_en = 1'b0;
    mem[1] = 32'd20; mem[17] = 32'd6;
    dif.dump_ready = 1'b1;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k == 3) dump_start = 1'b1;
      if (k == 6) dump_start = 1'b0;
      vecs++;
      if (dif.dump_valid !== 1'b1 || dif.dump_busy !== 1'b1 ||
          dif.dump_addr !== 5'(k) || dif.dump_data !== mem[k] ||
          dif.dump_last !== (k == 31)) begin
        errs++;
        $display("FAIL dump_full beat%0d: got v=%b b=%b addr=%0d data=%h last=%b required v=1 b=1 addr=%0d data=%h last=%b",
                 k, dif.dump_valid, dif.dump_busy, dif.dump_addr,
                 dif.dump_data, dif.dump_last, k, mem[k], (k == 31));
      end
      tick();
    end
    vecs++;
    if (dif.dump_busy !== 1'b0 || dif.dump_valid !== 1'b0) begin
      errs++;
      $display("FAIL dump_full_end: got busy=%b valid=%b required 0 0",
               dif.dump_busy, dif.dump_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ebeat [32];
    logic        pat [4];
    logic        r;
    bit          done, w5;
    int          k, cyc;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int i = 0; i < 32; i++) ebeat[i] = mem[i];
    ebeat[9] = 32'h99;
    k = 0; cyc = 0; done = 0; w5 = 0;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    while (!done && cyc < 200) begin
      vecs++;
      if (dif.dump_valid !== 1'b1 || dif.dump_addr !== 5'(k) ||
          dif.dump_data !== ebeat[k] ||
          dif.dump_last !== (k == 31)) begin
        errs++;
        $display("FAIL stall cyc%0d: got v=%b addr=%0d data=%h last=%b required v=1 addr=%0d data=%h last=%b",
                 cyc, dif.dump_valid, dif.dump_addr, dif.dump_data,
                 dif.dump_last, k, ebeat[k], (k == 31));
      end
      r = pat[cyc % 4];
      dif.dump_ready = r;
      wr_en = 1'b0;
      if (k == 5 && !r && !w5) begin
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h77; w5 = 1;
      end
      if (k == 8 && r) begin
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
      end
      tick();
      cyc++;
      if (r) begin
        if (k == 31) done = 1;
        else k++;
      end
    end
    wr_en = 1'b0;
    dif.dump_ready = 1'b1;
    mem[5] = 32'h77; mem[9] = 32'h99;
    vecs++;
    if (!done || dif.dump_busy !== 1'b0) begin
      errs++;
      $display("FAIL stall_end: got done=%0d busy=%b required 1 0",
               done, dif.dump_busy);
    end
    rd_addr_a = 5'd5; rd_addr_b = 5'd9;
    #1;
    vecs++;
    if (rd_data_a !== 32'h77 || rd_data_b !== 32'h99) begin
      errs++;
      $display("FAIL stall_writes: got r5=%h r9=%h required 77 99",
               rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_reset_mid();
    dif.dump_ready = 1'b1;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    vecs++;
    if (dif.dump_addr !== 5'd10 || dif.dump_valid !== 1'b1) begin
      errs++;
      $display("FAIL mid_pre: got addr=%0d valid=%b required 10 1",
               dif.dump_addr, dif.dump_valid);
    end
    #2;
    rst_n = 1'b0;
    rd_addr_a = 5'd16; rd_addr_b = 5'd1;
    #1;
    vecs++;
    if ({dif.dump_busy, dif.dump_valid, dif.dump_last,
         dif.dump_addr, dif.dump_data} !== '0) begin
      errs++;
      $display("FAIL mid_reset_dump: got busy=%b valid=%b last=%b addr=%h data=%h required all 0",
               dif.dump_busy, dif.dump_valid, dif.dump_last,
               dif.dump_addr, dif.dump_data);
    end
    vecs++;
    if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
      errs++;
      $display("FAIL mid_reset_rf: got r16=%h r1=%h required 0 0",
               rd_data_a, rd_data_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    tick();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      vecs++;
      if (dif.dump_addr !== 5'(k) || dif.dump_data !== 32'h0 ||
          dif.dump_valid !== 1'b1) begin
        errs++;
        $display("FAIL restart beat%0d: got addr=%0d data=%h valid=%b required %0d 0 1",
                 k, dif.dump_addr, dif.dump_data, dif.dump_valid, k);
      end
      tick();
    end
    vecs++;
    if (dif.dump_busy !== 1'b0) begin
      errs++;
      $display("FAIL restart_end: got busy=%b required 0", dif.dump_busy);
    end
  endtask

  task automatic test_param_sweep();
    s_wr_en = 1'b1; s_wr_addr = 3'd0; s_wr_data = 16'h1234;
    tick();
    s_wr_en = 1'b0;
    s_rd_addr_a = 3'd0;
    #1;
    vecs++;
    if (s_rd_data_a !== 16'h1234) begin
      errs++;
      $display("FAIL small_r0: got %h required 1234", s_rd_data_a);
    end
    sif.dump_ready = 1'b1;
    s_dump_start = 1'b1;
    tick();
    s_dump_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      vecs++;
      if (sif.dump_valid !== 1'b1 || sif.dump_addr !== 3'(k) ||
          sif.dump_data !== ((k == 0) ? 16'h1234 : 16'h0) ||
          sif.dump_last !== (k == 7)) begin
        errs++;
        $display("FAIL small_dump beat%0d: got v=%b addr=%0d data=%h last=%b required v=1 addr=%0d data=%h last=%b",
                 k, sif.dump_valid, sif.dump_addr, sif.dump_data,
                 sif.dump_last, k, (k == 0) ? 16'h1234 : 16'h0,
                 (k == 7));
      end
      tick();
    end
    vecs++;
    if (sif.dump_busy !== 1'b0) begin
      errs++;
      $display("FAIL small_end: got busy=%b required 0", sif.dump_busy);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_dump_full();
    test_backpressure();
    test_reset_mid();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
